pit_count_mc: RTL and testbench
===============================

Name: pit_count_mc

Overview:
- Multi-channel successor to the single PIT main counter: NUM_CH independent modulo counters share one prescaler tick.
- Each channel has its own modulo value, which is shadow-latched so mid-period writes are safe.
- Each channel supports periodic or one-shot mode and can optionally cascade from the previous channel's rollover.
- Sits between the prescaler and the PIT register/interrupt logic; drives per-channel flags, output pulses and a merged, maskable interrupt.

Parameters:
- COUNT_SIZE, 16, width of each channel's counter and modulo value.
- NUM_CH, 4, number of channels (1..16).

Ports:
- bus_clk  input  1  reference clock; all state changes on its rising edge.
- sync_reset  input  1  synchronous, active-high reset.
- prescale_out  input  1  single-cycle increment tick from the prescaler.
- ch_en  input  NUM_CH  per-channel enable; 0 holds the channel cleared.
- ch_oneshot  input  NUM_CH  1 = one-shot mode, 0 = periodic mode.
- ch_chain  input  NUM_CH  1 = channel i ticks on rollover of channel i-1; ignored for channel 0.
- mod_value  input  NUM_CH x COUNT_SIZE  per-channel count divisor (packed array).
- pit_flg_clr  input  NUM_CH  per-channel flag clear.
- irq_en  input  NUM_CH  per-channel interrupt mask (1 = enabled).
- cnt_n  output  NUM_CH x COUNT_SIZE  per-channel counter value.
- cnt_flag_o  output  NUM_CH  sticky per-channel rollover flag.
- pit_o  output  NUM_CH  one-cycle registered rollover pulse.
- done_o  output  NUM_CH  one-shot expired.
- irq_o  output  1  OR of (cnt_flag_o & irq_en); combinational from registers.

Behaviour:
- Reset (sync_reset=1 at clock edge):
  - cnt_n=1, shadow_mod=0, cnt_flag_o=0, pit_o=0, done_o=0.
  - sync_reset overrides all other inputs. Mid-count reset discards the period in progress.
- Per-channel definitions (all use the registered shadow_mod, never mod_value directly):
  - tick = (chain && i>0) ? roll[i-1] : prescale_out.
  - active = ch_en && !done.
  - no_div = (shadow_mod <= 1).
  - roll = tick && active && (cnt_n==shadow_mod || no_div).
- Cascade: roll[i-1] feeds tick[i] combinationally in the same cycle. The full chain ripples in one cycle, with no extra latency.
- Counter update priority, per channel, highest first:
  1. !ch_en: cnt_n=1, shadow_mod<=mod_value, done<=0.
  2. roll: cnt_n<=1, shadow_mod<=mod_value, done<=ch_oneshot.
  3. tick && active: cnt_n<=cnt_n+1.
  4. Otherwise hold.
- Modulo reload: a mod_value change while enabled takes effect only at the next rollover, or while disabled. The current period is never truncated or extended.
- Period: shadow_mod=N>=2 gives one roll per N ticks. N=0 or 1 gives a roll on every tick, and cnt_n stays at 1.
- Wrap: cnt_n must never exceed shadow_mod. Arithmetic is unsigned, COUNT_SIZE bits. Roll at shadow_mod = 2^COUNT_SIZE-1 is legal.
- cnt_flag_o:
  - Cleared when !ch_en or pit_flg_clr; clear wins over a simultaneous roll.
  - Otherwise set on roll.
- pit_o[i] <= roll[i] && ch_en[i], registered, so the pulse appears one cycle after the roll edge.
- One-shot:
  - After the first roll, done_o=1, cnt_n holds at 1, and no further roll, flag set or pit_o occurs.
  - Only ch_en deassertion rearms the channel. Changing ch_oneshot while done=1 does not rearm.
  - A done channel produces no roll, so chained successors stall.
- Disabling a channel mid-period: cnt_n returns to 1 next cycle, its flag clears, and no pit_o pulse is produced.

Decomposition:
- Package pit_mc_pkg holds:
  - MAX_CH=16 constant.
  - Mode enum pit_mode_e {PIT_PERIODIC, PIT_ONESHOT}.
  - Typedef for the per-channel status struct {cnt, flag, done}.
- Sub-module pit_mc_chan: one channel's counter, shadow register, flag, done and pit_o, with the roll output exported.
- The top level instantiates NUM_CH channels in a generate loop, muxes tick (prescale_out vs roll[i-1]) and builds irq_o.

Test Plan:
- Periodic: ch0 mod=4, prescale_out every cycle, en=1 → cnt_n goes 1,2,3,4,1; pit_o pulses once per 4 ticks, one cycle after cnt_n==4; flag sets and stays until pit_flg_clr.
- Shadow reload: ch0 mod=10, write mod=3 when cnt_n=5 → count continues to 10, then periods of 3.
- One-shot: ch1 mod=5, oneshot=1 → exactly one pit_o pulse after 5 ticks, done_o=1, cnt_n=1 thereafter; toggle ch_en 0→1 → one more pulse after 5 ticks.
- Cascade: ch0 mod=3, ch1 mod=4, chain[1]=1 → ch1 pit_o once per 12 ticks, in the same cycle as ch0's 4th pulse.
- Edge cases:
  - mod=0 and mod=1 → pit_o on every tick.
  - pit_flg_clr coincident with roll → flag reads 0.
  - irq_en=0 → irq_o stays 0 while the flag is set.
- sync_reset asserted mid-count (cnt_n=7) → next cycle all cnt_n=1, all flags, pit_o, done_o and irq_o = 0.

Source files
------------

// File: rtl/pit_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pit_mc_pkg
//  Purpose  : Shared constants and types for the multi-channel PIT counter.
//  Revision : 1.0  initial release
// ============================================================================
package pit_mc_pkg;

    localparam int MAX_CH    = 16;
    localparam int MAX_CNT_W = 32;

    typedef enum logic [0:0] {
        PIT_PERIODIC = 1'b0,
        PIT_ONESHOT  = 1'b1
    } pit_mode_e;

    // cnt is carried at the widest supported width; owners use the low bits
    typedef struct packed {
        logic [MAX_CNT_W-1:0] cnt;
        logic                 flag;
        logic                 done;
    } pit_status_t;

endpackage : pit_mc_pkg
`default_nettype wire

// File: rtl/pit_mc_chan.sv
`default_nettype none
// ============================================================================
//  Module   : pit_mc_chan
//  Purpose  : One PIT channel: modulo counter, shadow modulo, flag, done, pulse.
//  Revision : 1.0  initial release
// ============================================================================
module pit_mc_chan
    import pit_mc_pkg::*;
#(
    parameter int COUNT_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_tick,
    input  logic                  i_en,
    input  logic                  i_oneshot,
    input  logic [COUNT_SIZE-1:0] i_mod,
    input  logic                  i_flg_clr,
    output pit_status_t           o_status,
    output logic                  o_pit,
    output logic                  o_roll
);

    localparam logic [COUNT_SIZE-1:0] C_ONE = COUNT_SIZE'(1);

    logic [COUNT_SIZE-1:0] cnt_q, cnt_d;
    logic [COUNT_SIZE-1:0] shadow_q, shadow_d;
    logic                  flag_q, flag_d;
    logic                  done_q, done_d;
    logic                  pit_q, pit_d;

    pit_mode_e w_mode;
    logic      w_active;
    logic      w_no_div;

    assign w_mode   = i_oneshot ? PIT_ONESHOT : PIT_PERIODIC;
    assign w_active = i_en & ~done_q;
    assign w_no_div = (shadow_q <= C_ONE);
    // Comparison uses the shadow copy so a new modulo never cuts a period short
    assign o_roll   = i_tick & w_active & ((cnt_q == shadow_q) | w_no_div);

    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        done_d   = done_q;
        flag_d   = flag_q;
        pit_d    = o_roll & i_en;

        if (!i_en) begin
            cnt_d    = C_ONE;
            shadow_d = i_mod;
            done_d   = 1'b0;
        end else if (o_roll) begin
            cnt_d    = C_ONE;
            shadow_d = i_mod;
            done_d   = (w_mode == PIT_ONESHOT);
        end else if (i_tick && w_active) begin
            cnt_d    = cnt_q + C_ONE;
        end

        if (!i_en || i_flg_clr) begin
            flag_d = 1'b0;
        end else if (o_roll) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= C_ONE;
            shadow_q <= '0;
            flag_q   <= 1'b0;
            done_q   <= 1'b0;
            pit_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            flag_q   <= flag_d;
            done_q   <= done_d;
            pit_q    <= pit_d;
        end
    end

    always_comb begin
        o_status.cnt  = MAX_CNT_W'(cnt_q);
        o_status.flag = flag_q;
        o_status.done = done_q;
    end

    assign o_pit = pit_q;

endmodule : pit_mc_chan
`default_nettype wire

// File: rtl/pit_count_mc.sv
`default_nettype none
// ============================================================================
//  Module   : pit_count_mc
//  Purpose  : NUM_CH cascadable modulo counters sharing one prescaler tick.
//  Revision : 1.0  initial release
// ============================================================================
module pit_count_mc
    import pit_mc_pkg::*;
#(
    parameter int COUNT_SIZE = 16,
    parameter int NUM_CH     = 4
) (
    input  logic                                 bus_clk,
    input  logic                                 sync_reset,
    input  logic                                 prescale_out,
    input  logic [NUM_CH-1:0]                    ch_en,
    input  logic [NUM_CH-1:0]                    ch_oneshot,
    input  logic [NUM_CH-1:0]                    ch_chain,
    input  logic [NUM_CH-1:0][COUNT_SIZE-1:0]    mod_value,
    input  logic [NUM_CH-1:0]                    pit_flg_clr,
    input  logic [NUM_CH-1:0]                    irq_en,
    output logic [NUM_CH-1:0][COUNT_SIZE-1:0]    cnt_n,
    output logic [NUM_CH-1:0]                    cnt_flag_o,
    output logic [NUM_CH-1:0]                    pit_o,
    output logic [NUM_CH-1:0]                    done_o,
    output logic                                 irq_o
);

    logic [NUM_CH-1:0] w_tick;
    logic [NUM_CH-1:0] w_roll;
    pit_status_t       w_status [NUM_CH];

    // Channel 0 has no predecessor, so its chain bit has no meaning
    logic w_unused_chain0;
    assign w_unused_chain0 = ch_chain[0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        if (i == 0) begin : g_first
            assign w_tick[i] = prescale_out;
        end else begin : g_cascade
            // Ripples through the whole chain within one cycle
            assign w_tick[i] = ch_chain[i] ? w_roll[i-1] : prescale_out;
        end

        pit_mc_chan #(
            .COUNT_SIZE (COUNT_SIZE)
        ) u_chan (
            .clk       (bus_clk),
            .rst       (sync_reset),
            .i_tick    (w_tick[i]),
            .i_en      (ch_en[i]),
            .i_oneshot (ch_oneshot[i]),
            .i_mod     (mod_value[i]),
            .i_flg_clr (pit_flg_clr[i]),
            .o_status  (w_status[i]),
            .o_pit     (pit_o[i]),
            .o_roll    (w_roll[i])
        );

        assign cnt_n[i]      = w_status[i].cnt[COUNT_SIZE-1:0];
        assign cnt_flag_o[i] = w_status[i].flag;
        assign done_o[i]     = w_status[i].done;

        if (COUNT_SIZE < MAX_CNT_W) begin : g_pad
            logic [MAX_CNT_W-COUNT_SIZE-1:0] w_unused_hi;
            assign w_unused_hi = w_status[i].cnt[MAX_CNT_W-1:COUNT_SIZE];
        end
    end

    assign irq_o = |(cnt_flag_o & irq_en);

endmodule : pit_count_mc
`default_nettype wire

// File: tb/tb_pit_count_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pit_count_mc
//  Purpose  : Directed self-checking bench for pit_count_mc.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pit_count_mc;

    localparam int CW = 8;
    localparam int NC = 4;

    logic                     bus_clk = 1'b0;
    logic                     sync_reset;
    logic                     prescale_out;
    logic [NC-1:0]            ch_en, ch_oneshot, ch_chain, pit_flg_clr, irq_en;
    logic [NC-1:0][CW-1:0]    mod_value;
    logic [NC-1:0][CW-1:0]    cnt_n;
    logic [NC-1:0]            cnt_flag_o, pit_o, done_o;
    logic                     irq_o;

    int total = 0;
    int bad   = 0;
    int npulse;

    pit_count_mc #(
        .COUNT_SIZE (CW),
        .NUM_CH     (NC)
    ) dut (
        .bus_clk      (bus_clk),
        .sync_reset   (sync_reset),
        .prescale_out (prescale_out),
        .ch_en        (ch_en),
        .ch_oneshot   (ch_oneshot),
        .ch_chain     (ch_chain),
        .mod_value    (mod_value),
        .pit_flg_clr  (pit_flg_clr),
        .irq_en       (irq_en),
        .cnt_n        (cnt_n),
        .cnt_flag_o   (cnt_flag_o),
        .pit_o        (pit_o),
        .done_o       (done_o),
        .irq_o        (irq_o)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic step();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        sync_reset   = 1'b1;
        prescale_out = 1'b0;
        ch_en        = '0;
        ch_oneshot   = '0;
        ch_chain     = '0;
        pit_flg_clr  = '0;
        irq_en       = '0;
        mod_value    = '0;
        step();
        step();
        chk("rst_cnt",  cnt_n, 32'h01010101);
        chk("rst_flag", {28'd0, cnt_flag_o}, 32'd0);
        chk("rst_pit",  {28'd0, pit_o}, 32'd0);
        chk("rst_done", {28'd0, done_o}, 32'd0);
        chk("rst_irq",  {31'd0, irq_o}, 32'd0);

        // Periodic, modulo 4
        sync_reset   = 1'b0;
        mod_value[0] = 8'd4;
        step();
        ch_en[0]     = 1'b1;
        prescale_out = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("per_cnt", {24'd0, cnt_n[0]}, 32'(k + 1));
            chk("per_nopit", {31'd0, pit_o[0]}, 32'd0);
        end
        step();
        chk("per_wrap_cnt", {24'd0, cnt_n[0]}, 32'd1);
        chk("per_pit", {31'd0, pit_o[0]}, 32'd1);
        chk("per_flag", {31'd0, cnt_flag_o[0]}, 32'd1);
        step();
        chk("per_cnt2", {24'd0, cnt_n[0]}, 32'd2);
        chk("per_pit_once", {31'd0, pit_o[0]}, 32'd0);
        chk("per_flag_sticky", {31'd0, cnt_flag_o[0]}, 32'd1);
        chk("irq_masked", {31'd0, irq_o}, 32'd0);
        irq_en[0] = 1'b1;
        #1;
        chk("irq_unmasked", {31'd0, irq_o}, 32'd1);
        step();
        step();
        chk("per_cnt4", {24'd0, cnt_n[0]}, 32'd4);
        pit_flg_clr[0] = 1'b1;
        step();
        chk("clr_vs_roll_flag", {31'd0, cnt_flag_o[0]}, 32'd0);
        chk("clr_vs_roll_pit", {31'd0, pit_o[0]}, 32'd1);
        chk("clr_irq", {31'd0, irq_o}, 32'd0);
        pit_flg_clr[0] = 1'b0;
        step();
        step();
        chk("pre_dis_cnt", {24'd0, cnt_n[0]}, 32'd3);
        ch_en[0] = 1'b0;
        step();
        chk("dis_cnt", {24'd0, cnt_n[0]}, 32'd1);
        chk("dis_pit", {31'd0, pit_o[0]}, 32'd0);
        step();
        chk("dis_hold", {24'd0, cnt_n[0]}, 32'd1);

        // Shadow reload: 10 then 3
        mod_value[0] = 8'd10;
        step();
        ch_en[0] = 1'b1;
        repeat (4) step();
        chk("sh_cnt5", {24'd0, cnt_n[0]}, 32'd5);
        mod_value[0] = 8'd3;
        repeat (5) step();
        chk("sh_cnt10", {24'd0, cnt_n[0]}, 32'd10);
        chk("sh_nopit", {31'd0, pit_o[0]}, 32'd0);
        step();
        chk("sh_roll_cnt", {24'd0, cnt_n[0]}, 32'd1);
        chk("sh_roll_pit", {31'd0, pit_o[0]}, 32'd1);
        step();
        step();
        chk("sh_new_cnt3", {24'd0, cnt_n[0]}, 32'd3);
        chk("sh_new_nopit", {31'd0, pit_o[0]}, 32'd0);
        step();
        chk("sh_new_roll", {31'd0, pit_o[0]}, 32'd1);
        ch_en[0]  = 1'b0;
        irq_en[0] = 1'b0;

        // One-shot on ch1, modulo 5
        mod_value[1]  = 8'd5;
        ch_oneshot[1] = 1'b1;
        step();
        ch_en[1] = 1'b1;
        repeat (4) step();
        chk("os_cnt5", {24'd0, cnt_n[1]}, 32'd5);
        chk("os_notdone", {31'd0, done_o[1]}, 32'd0);
        step();
        chk("os_pit", {31'd0, pit_o[1]}, 32'd1);
        chk("os_done", {31'd0, done_o[1]}, 32'd1);
        chk("os_cnt1", {24'd0, cnt_n[1]}, 32'd1);
        chk("os_flag", {31'd0, cnt_flag_o[1]}, 32'd1);
        npulse = 0;
        repeat (10) begin
            step();
            npulse += int'(pit_o[1]);
        end
        chk("os_no_more_pulses", 32'(npulse), 32'd0);
        chk("os_cnt_hold", {24'd0, cnt_n[1]}, 32'd1);
        ch_oneshot[1] = 1'b0;
        step();
        chk("os_mode_no_rearm", {31'd0, done_o[1]}, 32'd1);
        ch_en[1] = 1'b0;
        step();
        chk("os_rearm_done", {31'd0, done_o[1]}, 32'd0);
        chk("os_dis_flag", {31'd0, cnt_flag_o[1]}, 32'd0);
        ch_en[1]      = 1'b1;
        ch_oneshot[1] = 1'b1;
        repeat (4) step();
        chk("os2_nopit", {31'd0, pit_o[1]}, 32'd0);
        step();
        chk("os2_pit", {31'd0, pit_o[1]}, 32'd1);
        chk("os2_done", {31'd0, done_o[1]}, 32'd1);

        // Cascade: ch1 counts ch0 rollovers
        ch_en         = '0;
        ch_oneshot    = '0;
        mod_value[0]  = 8'd3;
        mod_value[1]  = 8'd4;
        ch_chain[1]   = 1'b1;
        step();
        ch_en[1:0] = 2'b11;
        for (int k = 1; k <= 24; k++) begin
            step();
            chk("casc_pit0", {31'd0, pit_o[0]}, (k % 3 == 0) ? 32'd1 : 32'd0);
            chk("casc_pit1", {31'd0, pit_o[1]}, (k % 12 == 0) ? 32'd1 : 32'd0);
        end
        ch_en    = '0;
        ch_chain = '0;

        // Modulo 0 and 1 roll on every tick
        mod_value[2] = 8'd0;
        mod_value[3] = 8'd1;
        step();
        ch_en[3:2] = 2'b11;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mod0_pit", {31'd0, pit_o[2]}, 32'd1);
            chk("mod1_pit", {31'd0, pit_o[3]}, 32'd1);
            chk("mod0_cnt", {24'd0, cnt_n[2]}, 32'd1);
            chk("mod1_cnt", {24'd0, cnt_n[3]}, 32'd1);
        end
        prescale_out = 1'b0;
        step();
        chk("notick_pit", {30'd0, pit_o[3:2]}, 32'd0);
        prescale_out = 1'b1;
        ch_en        = '0;

        // Full-scale modulo 255
        mod_value[2] = 8'd255;
        step();
        ch_en[2] = 1'b1;
        repeat (254) step();
        chk("max_cnt", {24'd0, cnt_n[2]}, 32'd255);
        chk("max_nopit", {31'd0, pit_o[2]}, 32'd0);
        step();
        chk("max_wrap_cnt", {24'd0, cnt_n[2]}, 32'd1);
        chk("max_wrap_pit", {31'd0, pit_o[2]}, 32'd1);
        ch_en = '0;

        // Reset mid-count
        mod_value[0]  = 8'd10;
        mod_value[1]  = 8'd1;
        mod_value[3]  = 8'd1;
        ch_oneshot[1] = 1'b1;
        irq_en        = '1;
        step();
        ch_en = 4'b1011;
        repeat (6) step();
        chk("pre_rst_cnt7", {24'd0, cnt_n[0]}, 32'd7);
        chk("pre_rst_flag3", {31'd0, cnt_flag_o[3]}, 32'd1);
        chk("pre_rst_done1", {31'd0, done_o[1]}, 32'd1);
        chk("pre_rst_irq", {31'd0, irq_o}, 32'd1);
        sync_reset = 1'b1;
        step();
        chk("mid_rst_cnt", cnt_n, 32'h01010101);
        chk("mid_rst_flag", {28'd0, cnt_flag_o}, 32'd0);
        chk("mid_rst_pit", {28'd0, pit_o}, 32'd0);
        chk("mid_rst_done", {28'd0, done_o}, 32'd0);
        chk("mid_rst_irq", {31'd0, irq_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pit_count_mc
`default_nettype wire
